// File: rtl/adder_arb_pkg.sv
// Shared types for the adder_arbiter slice.
// Holds the FSM state encoding and the default datapath width.
package adder_arb_pkg;

   localparam int ADDER_WIDTH = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } arbState_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin grant: picks the first asserted request at or above the pointer,
// wrapping past NUM_REQ-1 back to 0.
module rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [ID_W-1:0]    i_ptr,
   output logic [NUM_REQ-1:0] o_grant,
   output logic [ID_W-1:0]    o_grant_idx,
   output logic               o_any_valid
);

   int w_idx;

   // Scanning from farthest to nearest lets the closest hit to the pointer overwrite the others.
   always_comb begin
      o_grant     = '0;
      o_grant_idx = '0;
      o_any_valid = 1'b0;
      w_idx       = 0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         w_idx = int'(i_ptr) + k;
         if (w_idx >= NUM_REQ) begin
            w_idx = w_idx - NUM_REQ;
         end
         if (i_req[w_idx]) begin
            o_grant        = '0;
            o_grant[w_idx] = 1'b1;
            o_grant_idx    = ID_W'(w_idx);
            o_any_valid    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/adder_arbiter.sv
// Round-robin sequencer sharing one external add/sub datapath among NUM_REQ requesters.
// Define ADDER_ARB_OVF_EN to add the rsp_ovf signed-overflow response output.
module adder_arbiter
   import adder_arb_pkg::*;
#(
   parameter int  NUM_REQ = 4,
   parameter int  WIDTH   = ADDER_WIDTH,
   localparam int ID_W    = $clog2(NUM_REQ)
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic [NUM_REQ-1:0]       req_valid,
   output logic [NUM_REQ-1:0]       req_ready,
   input  logic [NUM_REQ*WIDTH-1:0] req_a,
   input  logic [NUM_REQ*WIDTH-1:0] req_b,
   input  logic [NUM_REQ-1:0]       req_sub,
   output logic [WIDTH-1:0]         add_a,
   output logic [WIDTH-1:0]         add_b,
   output logic                     add_cin,
   output logic                     add_sub,
   input  logic [WIDTH-1:0]         add_sum,
   input  logic                     add_cout,
   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic [ID_W-1:0]          rsp_id,
   output logic [WIDTH-1:0]         rsp_sum,
   output logic                     rsp_cout
`ifdef ADDER_ARB_OVF_EN
   ,
   output logic                     rsp_ovf
`endif
);

   arbState_t          r_state;
   arbState_t          w_nextState;
   logic [ID_W-1:0]    r_ptr;
   logic [ID_W-1:0]    r_id;
   logic [WIDTH-1:0]   r_a;
   logic [WIDTH-1:0]   r_b;
   logic               r_sub;
   logic [NUM_REQ-1:0] w_grant;
   logic [ID_W-1:0]    w_grantIdx;
   logic               w_anyValid;
   logic               w_accept;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_rrArbiter (
      .i_req       (req_valid),
      .i_ptr       (r_ptr),
      .o_grant     (w_grant),
      .o_grant_idx (w_grantIdx),
      .o_any_valid (w_anyValid)
   );

   // Gating with reset_n keeps req_ready low while reset is held, even though the FSM sits in IDLE.
   assign w_accept  = (r_state == IDLE) && w_anyValid;
   assign req_ready = (reset_n && (r_state == IDLE)) ? w_grant : '0;

   assign add_a   = r_a;
   assign add_b   = r_b;
   assign add_sub = r_sub;
   assign add_cin = 1'b0;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE:    if (w_anyValid) w_nextState = EXEC;
         EXEC:    w_nextState = RESP;
         RESP:    if (rsp_ready) w_nextState = IDLE;
         default: w_nextState = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_ptr     <= '0;
         r_id      <= '0;
         r_a       <= '0;
         r_b       <= '0;
         r_sub     <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_id    <= '0;
         rsp_sum   <= '0;
         rsp_cout  <= 1'b0;
      end else begin
         if (w_accept) begin
            r_a   <= req_a[int'(w_grantIdx) * WIDTH +: WIDTH];
            r_b   <= req_b[int'(w_grantIdx) * WIDTH +: WIDTH];
            r_sub <= req_sub[w_grantIdx];
            r_id  <= w_grantIdx;
            r_ptr <= (w_grantIdx == ID_W'(NUM_REQ - 1)) ? '0 : w_grantIdx + ID_W'(1);
         end
         if (r_state == EXEC) begin
            rsp_valid <= 1'b1;
            rsp_id    <= r_id;
            rsp_sum   <= add_sum;
            rsp_cout  <= add_cout;
         end else if ((r_state == RESP) && rsp_ready) begin
            rsp_valid <= 1'b0;
         end
      end
   end

`ifdef ADDER_ARB_OVF_EN
   logic w_ovf;

   // Subtraction flips the sign test on B because the adder negates it internally.
   assign w_ovf = r_sub ?
      ((r_a[WIDTH-1] != r_b[WIDTH-1]) && (add_sum[WIDTH-1] != r_a[WIDTH-1])) :
      ((r_a[WIDTH-1] == r_b[WIDTH-1]) && (add_sum[WIDTH-1] != r_a[WIDTH-1]));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rsp_ovf <= 1'b0;
      end else if (r_state == EXEC) begin
         rsp_ovf <= w_ovf;
      end
   end
`endif

endmodule
